// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked execute-stage ALU with optional iterative multiplier
//
// Accepts one operation per cycle on a valid/ready input channel. Each result
// goes into a one-entry output register, which is drained over a valid/ready
// output channel.
// Optional feature macro: ALU_MUL_EN compiles in the shift-add multiplier (op 14).
// Without ALU_MUL_EN, op 14 is an illegal opcode.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake (in_ready is combinational)
//   op, op1, op2        opcode and operands, sampled on the accept edge only
//   out_valid, out_ready output handshake
//   res                 result
//   carry, ovf, z, err  ADD carry / SUB borrow, signed overflow, zero, illegal op
//   busy                multiplier iterating or waiting for the output slot
module alu_pipe #(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         ovf,
  output logic         z,
  output logic         err,
  output logic         busy
);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SEQ  = 4'd9;
  localparam logic [3:0] OP_SNE  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLE  = 4'd12;
  localparam logic [3:0] OP_SLTU = 4'd13;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd14;
`endif

  // The slot is free if it is empty or if it is drained on this edge.
  logic slot_free;
  logic accept;
  logic single_ld;
  logic mul_ld;
  logic [W-1:0] mul_res;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   c_res;
  logic           c_carry;
  logic           c_ovf;
  logic           c_err;

  assign sum   = {1'b0, op1} + {1'b0, op2};
  // The borrow is taken from bit W of the zero-extended difference.
  assign diff  = {1'b0, op1} - {1'b0, op2};
  assign shamt = op2[SHW-1:0];

  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_err   = 1'b0;
    case (op)
      OP_ADD: begin
        c_res   = sum[W-1:0];
        c_carry = sum[W];
        c_ovf   = (op1[W-1] == op2[W-1]) && (sum[W-1] != op1[W-1]);
      end
      OP_SUB: begin
        c_res   = diff[W-1:0];
        c_carry = diff[W];
        c_ovf   = (op1[W-1] != op2[W-1]) && (diff[W-1] != op1[W-1]);
      end
      OP_AND:  c_res = op1 & op2;
      OP_OR:   c_res = op1 | op2;
      OP_XOR:  c_res = op1 ^ op2;
      OP_SLL:  c_res = op1 << shamt;
      OP_SRL:  c_res = op1 >> shamt;
      OP_SRA:  c_res = W'($signed(op1) >>> shamt);
      OP_SEQ:  c_res = {{(W-1){1'b0}}, (op1 == op2)};
      OP_SNE:  c_res = {{(W-1){1'b0}}, (op1 != op2)};
      OP_SLT:  c_res = {{(W-1){1'b0}}, ($signed(op1) <  $signed(op2))};
      OP_SLE:  c_res = {{(W-1){1'b0}}, ($signed(op1) <= $signed(op2))};
      OP_SLTU: c_res = {{(W-1){1'b0}}, (op1 < op2)};
      // Opcodes 0 and 15 are illegal. Op 14 is illegal when the multiplier is
      // absent. When the multiplier is present, op 14 never loads through this path.
      default: c_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------------
  // Iterative shift-add multiplier
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(W - 1);

  state_t       state;
  state_t       state_nx;
  logic [SHW:0] cnt;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [W-1:0] acc;
  logic [W-1:0] acc_step;
  logic         last_iter;

  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  // The final iteration and the result load share one edge. This puts
  // out_valid up right after edge W, counting from the accept edge 0.
  assign last_iter = (cnt == CNT_LAST);
  assign mul_res   = (state == S_MUL) ? acc_step : acc;
  assign in_ready  = (state == S_IDLE) && slot_free;
  assign busy      = (state != S_IDLE);
  assign single_ld = accept && (op != OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mul_ld   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && (op == OP_MUL)) state_nx = S_MUL;
      end
      S_MUL: begin
        if (last_iter) begin
          if (slot_free) begin
            state_nx = S_IDLE;
            mul_ld   = 1'b1;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (slot_free) begin
          state_nx = S_IDLE;
          mul_ld   = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (state == S_IDLE) begin
      if (accept && (op == OP_MUL)) begin
        cnt    <= '0;
        mcand  <= op1;
        mplier <= op2;
        acc    <= '0;
      end
    end else if (state == S_MUL) begin
      // On the last iteration acc keeps the final product, which S_WAIT needs
      // if the slot turns out to be occupied.
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + (SHW+1)'(1);
    end
  end
`else
  assign mul_ld    = 1'b0;
  assign mul_res   = '0;
  assign in_ready  = slot_free;
  assign busy      = 1'b0;
  assign single_ld = accept;
`endif

  // ---------------------------------------------------------------------------
  // One-entry output register. A load on the same edge as a consume
  // overwrites the slot, and out_valid stays high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      z         <= 1'b0;
      err       <= 1'b0;
    end else if (mul_ld) begin
      out_valid <= 1'b1;
      res       <= mul_res;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      z         <= (mul_res == '0);
      err       <= 1'b0;
    end else if (single_ld) begin
      out_valid <= 1'b1;
      res       <= c_res;
      carry     <= c_carry;
      ovf       <= c_ovf;
      z         <= (c_res == '0);
      err       <= c_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (W = 32)
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         carry;
  logic         ovf;
  logic         z;
  logic         err;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;

  alu_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .carry     (carry),
    .ovf       (ovf),
    .z         (z),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compares {out_valid, err, z, ovf, carry, res} as one word.
  task automatic check_out(input string tag, input logic v, input logic e, input logic zz,
                           input logic o, input logic c, input logic [W-1:0] r);
    check(tag, {27'd0, out_valid, err, z, ovf, carry, res}, {27'd0, v, e, zz, o, c, r});
  endtask

  localparam int NV = 18;
  logic [3:0]   v_op [NV];
  logic [W-1:0] v_a  [NV];
  logic [W-1:0] v_b  [NV];
  logic [W-1:0] v_r  [NV];
  logic [3:0]   v_f  [NV];  // {err, z, ovf, carry}

  initial begin
    int bad;

    //              ADD    ADD    SUB    SLT    SLTU   SRA    SLL    SRL    AND
    v_op = '{4'd1, 4'd1, 4'd2, 4'd11, 4'd13, 4'd8, 4'd6, 4'd7, 4'd3,
    //       OR    XOR   SEQ   SNE    SLE    SUB   ill0  ill15  SLT
             4'd4, 4'd5, 4'd9, 4'd10, 4'd12, 4'd2, 4'd0, 4'd15, 4'd11};
    v_a  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
             32'd1, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAAAAAA, 32'd7,
             32'd7, 32'h80000000, 32'h80000000, 32'd5, 32'd5, 32'd1};
    v_b  = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'h0000003F,
             32'd31, 32'h00000024, 32'hFF00FF00, 32'h0F000000, 32'hAAAAAAAA, 32'd7,
             32'd7, 32'h80000000, 32'd1, 32'd5, 32'd5, 32'hFFFFFFFF};
    v_r  = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hFFFFFFFF,
             32'h80000000, 32'h08000000, 32'hF000F000, 32'hFFF0F0F0, 32'h0, 32'd1,
             32'd0, 32'd1, 32'h7FFFFFFF, 32'h0, 32'h0, 32'd0};
    v_f  = '{4'b0101, 4'b0010, 4'b0001, 4'b0000, 4'b0100, 4'b0000,
             4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
             4'b0100, 4'b0000, 4'b0010, 4'b1100, 4'b1100, 4'b0100};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    op        = 4'd0;
    op1       = '0;
    op2       = '0;
    out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", {out_valid, busy, err, z, ovf, carry, res}, '0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Directed single-cycle vectors, streamed back-to-back
    in_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      op  = v_op[i];
      op1 = v_a[i];
      op2 = v_b[i];
      step();
      check_out($sformatf("vec%0d_op%0d", i, v_op[i]), 1'b1, v_f[i][3], v_f[i][2],
                v_f[i][1], v_f[i][0], v_r[i]);
    end
    in_valid = 1'b0;
    step();
    check("drain_out_valid", out_valid, 1'b0);

    // Backpressure: four ADDs, out_ready low for three cycles after the first
    op       = 4'd1;
    op2      = 32'd100;
    op1      = 32'd1;
    in_valid = 1'b1;
    step();
    check_out("bp_first", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd101);
    out_ready = 1'b0;
    op1       = 32'd2;
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold%0d", k), {out_valid, res}, {1'b1, 32'd101});
      check($sformatf("bp_stall_ready%0d", k), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_back", in_ready, 1'b1);
    step();
    check_out("bp_second", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd102);
    op1 = 32'd3;
    step();
    check_out("bp_third", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd103);
    op1 = 32'd4;
    step();
    check_out("bp_fourth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd104);
    in_valid = 1'b0;
    step();
    check("bp_no_dup", out_valid, 1'b0);

    // Reset while a result is held: err and z go low immediately
    out_ready = 1'b0;
    op        = 4'd0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("held_illegal", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_held_outputs", {out_valid, busy, err, z, ovf, carry, res}, '0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_held_in_ready", in_ready, 1'b1);
    step();

`ifdef ALU_MUL_EN
    // MUL latency: accepted on edge 0, result right after edge W
    op       = 4'd14;
    op1      = 32'h00010003;
    op2      = 32'h00000005;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op1      = 32'hDEADBEEF;
    op2      = 32'h12345678;
    check("mul_start", {busy, in_ready, out_valid}, 3'b100);
    bad = 0;
    for (int k = 1; k < W; k++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("mul_busy_throughout", bad, 0);
    step();
    check_out("mul_result", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0005000F);
    check("mul_done_flags", {busy, in_ready}, 2'b01);
    step();
    check("mul_consumed", out_valid, 1'b0);

    // MUL finishing with out_ready low: the result loads and then holds
    op       = 4'd14;
    op1      = 32'hFFFFFFFF;
    op2      = 32'hFFFFFFFF;
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k < W; k++) step();
    check("mul2_pending", out_valid, 1'b0);
    step();
    check_out("mul2_result", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
    step();
    step();
    check_out("mul2_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
    check("mul2_hold_flags", {busy, in_ready}, 2'b00);
    out_ready = 1'b1;
    step();
    check("mul2_consumed", out_valid, 1'b0);

    // Reset mid-MUL (cycle 5) discards the multiply
    op       = 4'd14;
    op1      = 32'd9;
    op2      = 32'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("mulrst_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mulrst_outputs", {out_valid, busy, err, z, ovf, carry, res}, '0);
    #2 rst_n = 1'b1;
    #1;
    check("mulrst_after", {in_ready, busy}, 2'b10);
    bad = 0;
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("mulrst_discarded", bad, 0);
`else
    // Without the multiplier, op 14 is a single-cycle illegal op
    op       = 4'd14;
    op1      = 32'd3;
    op2      = 32'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("mul_disabled", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check("mul_disabled_busy", busy, 1'b0);
    step();
    check("mul_disabled_consumed", out_valid, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
